// File: rtl/exp5_unidade_controle_pkg.sv
// State codes for the memory-game control unit. The hex decoder in the
// level-above top module and the testbench use these same codes.
package exp5_unidade_controle_pkg;

    typedef enum logic [3:0] {
        inicial     = 4'b0000,
        preparacao  = 4'b0001,
        espera      = 4'b0010,
        registra    = 4'b0100,
        comparacao  = 4'b0101,
        proximo     = 4'b0110,
        fim_acertou = 4'b1010,
        fim_errou   = 4'b1110,
        fim_timeout = 4'b1101
    } estado_t;

    // Any of the three terminal states (win, loss, timeout).
    function automatic logic is_fim(input estado_t e);
        return (e == fim_acertou) || (e == fim_errou) || (e == fim_timeout);
    endfunction

endpackage

// File: rtl/exp5_unidade_controle_contador_m.sv
// Modulo-M counter with synchronous clear and count enable; fim flags Q == M-1.
module contador_m #(
    parameter int M = 16,
    parameter int N = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         conta,
    output logic [N-1:0] Q,
    output logic         fim
);

    // Count register: clear has priority over enable, wraps after M-1.
    always_ff @(posedge clock) begin
        if (zera_s) begin
            Q <= '0;
        end else if (conta) begin
            Q <= (Q == N'(M - 1)) ? '0 : Q + N'(1);
        end
    end

    assign fim = (Q == N'(M - 1));

endmodule

// File: rtl/exp5_unidade_controle.sv
// Moore control unit sequencing the memory-game datapath: clear, wait for a
// play, register it, compare against the ROM word, advance or finish.
module exp5_unidade_controle
    import exp5_unidade_controle_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraC,
    output logic       contaC,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    estado_t         estado_atual;
    estado_t         estado_seg;
    logic [TW-1:0]   timer_q;
    logic            timer_fim;
    logic            timer_zera;
    logic            timer_conta;
    logic            timer_esgotado;

    // The timer restarts whenever a fresh wait window begins; it only runs
    // in espera and stops at its last value instead of wrapping.
    assign timer_zera     = reset || (estado_atual == preparacao) ||
                            (estado_atual == registra) || (estado_atual == proximo);
    assign timer_conta    = (estado_atual == espera) && !timer_fim;
    assign timer_esgotado = (timer_q == TW'(TIMEOUT_CICLOS - 1));

    contador_m #(
        .M (TIMEOUT_CICLOS),
        .N (TW)
    ) u_timer (
        .clock  (clock),
        .zera_s (timer_zera),
        .conta  (timer_conta),
        .Q      (timer_q),
        .fim    (timer_fim)
    );

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_atual <= inicial;
        end else begin
            estado_atual <= estado_seg;
        end
    end

    // Next-state logic; a play on the last allowed cycle beats the timeout.
    always_comb begin
        estado_seg = inicial;
        case (estado_atual)
            inicial:     estado_seg = iniciar ? preparacao : inicial;
            preparacao:  estado_seg = espera;
            espera: begin
                if (jogada_feita) begin
                    estado_seg = registra;
                end else if (timer_esgotado) begin
                    estado_seg = fim_timeout;
                end else begin
                    estado_seg = espera;
                end
            end
            registra:    estado_seg = comparacao;
            comparacao: begin
                if (!igual) begin
                    estado_seg = fim_errou;
                end else if (fimC) begin
                    estado_seg = fim_acertou;
                end else begin
                    estado_seg = proximo;
                end
            end
            proximo:     estado_seg = espera;
            fim_acertou,
            fim_errou,
            fim_timeout: estado_seg = iniciar ? preparacao : estado_atual;
            default:     estado_seg = inicial;
        endcase
    end

    // Moore outputs decoded from the current state only.
    always_comb begin
        zeraR     = 1'b0;
        registraR = 1'b0;
        zeraC     = 1'b0;
        contaC    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado_atual)
            preparacao: begin
                zeraR = 1'b1;
                zeraC = 1'b1;
            end
            registra:    registraR = 1'b1;
            proximo:     contaC    = 1'b1;
            fim_acertou: acertou   = 1'b1;
            fim_errou:   errou     = 1'b1;
            fim_timeout: timeout   = 1'b1;
            default: ;
        endcase
        pronto = is_fim(estado_atual);
    end

    assign db_estado = estado_atual;

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Bench for the memory-game control unit, wired to a behavioural datapath
// (address counter, synchronous default ROM, play register, comparator).
module tb_exp5_unidade_controle;
    import exp5_unidade_controle_pkg::*;

    localparam int M = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       jogada_feita = 1'b0;
    logic       igual;
    logic       fimC;
    logic       zeraR, registraR, zeraC, contaC;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    exp5_unidade_controle #(.TIMEOUT_CICLOS(M)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .jogada_feita (jogada_feita),
        .igual        (igual),
        .fimC         (fimC),
        .zeraR        (zeraR),
        .registraR    (registraR),
        .zeraC        (zeraC),
        .contaC       (contaC),
        .pronto       (pronto),
        .acertou      (acertou),
        .errou        (errou),
        .timeout      (timeout),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // Behavioural datapath
    logic [3:0] rom [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                             4'b0100, 4'b0010, 4'b0001, 4'b0001,
                             4'b0010, 4'b0010, 4'b0100, 4'b0100,
                             4'b1000, 4'b1000, 4'b0001, 4'b0100};
    logic [3:0] addr = 4'd0;
    logic [3:0] play_reg = 4'd0;
    logic [3:0] rom_q = 4'd0;
    logic [3:0] jogada_val = 4'd0;
    int         n_conta = 0;
    int         n_reg = 0;

    always @(posedge clock) begin
        if (zeraC) addr <= 4'd0;
        else if (contaC) addr <= addr + 4'd1;
        if (zeraR) play_reg <= 4'd0;
        else if (registraR) play_reg <= jogada_val;
        rom_q <= rom[addr];
        if (contaC) n_conta <= n_conta + 1;
        if (registraR) n_reg <= n_reg + 1;
    end

    assign igual = (rom_q == play_reg);
    assign fimC  = (addr == 4'd15);

    int checks = 0;
    int errors = 0;

    int gap [16];
    bit errada [16];
    bit lixo [16];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output table {zeraR,registraR,zeraC,contaC,pronto,acertou,errou,timeout}
    function automatic logic [7:0] saidas_de(input estado_t e);
        case (e)
            preparacao:  return 8'b1010_0000;
            registra:    return 8'b0100_0000;
            proximo:     return 8'b0001_0000;
            fim_acertou: return 8'b0000_1100;
            fim_errou:   return 8'b0000_1010;
            fim_timeout: return 8'b0000_1001;
            default:     return 8'b0000_0000;
        endcase
    endfunction

    task automatic chk_estado(input string tag, input estado_t e);
        chk({tag, "/estado"}, {28'd0, db_estado}, {28'd0, e});
        chk({tag, "/saidas"},
            {24'd0, zeraR, registraR, zeraC, contaC, pronto, acertou, errou, timeout},
            {24'd0, saidas_de(e)});
    endtask

    // Plays one game from inicial or an end state following gap/errada/lixo.
    // Schedule: espera entered at E; a play after g idle cycles gives registra
    // at E+g+1, comparacao at E+g+2, result at E+g+3, next espera at E+g+4.
    // With no play, fim_timeout at E+M.
    task automatic run_game(input string tag);
        int      base_c;
        int      base_r;
        int      aceitas;
        int      avancos;
        estado_t fim_esp;
        base_c  = n_conta;
        base_r  = n_reg;
        aceitas = 0;
        avancos = 0;
        fim_esp = fim_acertou;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk_estado({tag, "/prep"}, preparacao);
        tick();
        chk_estado({tag, "/espera0"}, espera);
        for (int k = 0; k < 16; k++) begin
            if (gap[k] >= M) begin
                repeat (M - 1) tick();
                chk_estado({tag, "/antes_timeout"}, espera);
                tick();
                fim_esp = fim_timeout;
                break;
            end
            repeat (gap[k]) tick();
            jogada_val   = errada[k] ? (rom[k] ^ 4'b0011) : rom[k];
            jogada_feita = 1'b1;
            tick();
            jogada_feita = 1'b0;
            aceitas++;
            chk_estado({tag, "/registra"}, registra);
            tick();
            chk_estado({tag, "/comparacao"}, comparacao);
            jogada_feita = lixo[k];
            tick();
            jogada_feita = 1'b0;
            if (errada[k]) begin
                fim_esp = fim_errou;
                break;
            end
            if (k == 15) break;
            chk_estado({tag, "/proximo"}, proximo);
            jogada_feita = lixo[k];
            tick();
            jogada_feita = 1'b0;
            chk_estado({tag, "/espera"}, espera);
            avancos++;
        end
        chk_estado({tag, "/fim"}, fim_esp);
        chk({tag, "/n_contaC"}, n_conta - base_c, avancos);
        chk({tag, "/n_registraR"}, n_reg - base_r, aceitas);
        chk({tag, "/endereco"}, {28'd0, addr}, avancos);
        tick();
        tick();
        chk_estado({tag, "/fim_estavel"}, fim_esp);
    endtask

    task automatic set_game(input int g, input bit lx);
        for (int k = 0; k < 16; k++) begin
            gap[k]    = g;
            errada[k] = 1'b0;
            lixo[k]   = lx;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk_estado("reset", inicial);
        tick();
        chk_estado("reset_ocioso", inicial);

        // All 16 plays correct, one every 5 cycles
        set_game(1, 1'b0);
        run_game("acerto_total");

        // Third play wrong
        set_game(0, 1'b0);
        errada[2] = 1'b1;
        run_game("erro_terceira");

        // No play at all: timeout
        set_game(M, 1'b0);
        run_game("timeout");

        // Play on the last allowed cycle wins over timeout
        set_game(M - 1, 1'b0);
        run_game("ultimo_ciclo");

        // Stray pulses during comparacao/proximo are ignored
        set_game(2, 1'b1);
        run_game("pulsos_ignorados");

        // iniciar held high in fim_errou: single preparacao, then espera
        set_game(0, 1'b0);
        errada[0] = 1'b1;
        run_game("erro_primeira");
        iniciar = 1'b1;
        tick();
        chk_estado("restart_prep", preparacao);
        tick();
        chk_estado("restart_espera", espera);
        tick();
        tick();
        chk_estado("restart_nao_reamostra", espera);
        chk("restart_endereco", {28'd0, addr}, 0);
        iniciar = 1'b0;

        // Reset in proximo
        reset = 1'b1;
        tick();
        reset = 1'b0;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        jogada_val   = rom[0];
        jogada_feita = 1'b1;
        tick();
        jogada_feita = 1'b0;
        tick();
        tick();
        chk_estado("pre_reset_proximo", proximo);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_estado("reset_em_proximo", inicial);
        chk("reset_mantem_endereco", {28'd0, addr}, 1);
        tick();
        chk_estado("reset_inicial_estavel", inicial);

        // Randomized games
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 16; k++) begin
                gap[k]    = ($urandom_range(0, 24) == 0) ? M : int'($urandom_range(0, M - 1));
                errada[k] = ($urandom_range(0, 14) == 0);
                lixo[k]   = $urandom_range(0, 1) != 0;
            end
            run_game($sformatf("aleatorio%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
